// File: rtl/nexys_starship_pkg.sv
// ---------------------------------------------------------------------------
// nexys_starship_pkg
// Shared definitions for the Nexys Starship top-monster timing controller:
//   - state_e         : one-hot controller state encoding
//   - *_BIT           : bit positions of each state inside the one-hot word
//   - LFSR_TAP_MASK   : feedback taps 16,14,13,11 of the 16-bit Fibonacci LFSR
//   - ATK_FLOOR       : shortest attack window the difficulty ramp may reach
//   - sat_add8        : 8-bit add that clamps at 255
// ---------------------------------------------------------------------------
package nexys_starship_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_WAIT   = 4'b0010,
    ST_ACTIVE = 4'b0100,
    ST_DEAD   = 4'b1000
  } state_e;

  localparam int IDLE_BIT   = 0;
  localparam int WAIT_BIT   = 1;
  localparam int ACTIVE_BIT = 2;
  localparam int DEAD_BIT   = 3;

  // Register bits 15,13,12,10 correspond to polynomial taps 16,14,13,11.
  localparam logic [15:0] LFSR_TAP_MASK = 16'hB400;

  localparam logic [7:0] ATK_FLOOR = 8'd16;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/nexys_starship_tm_ctrl_if.sv
// ---------------------------------------------------------------------------
// nexys_starship_tm_ctrl_if
// Game-side signal bundle of the top-monster timing controller.
//   play_flag, tick, fire_top          : game -> controller
//   top_monster_ctrl, top_timeout,
//   game_over_req, hits[7:0],
//   q_Idle, q_Wait, q_Active, q_Dead   : controller -> game
// Modports: slave = the controller, master = whoever drives the game inputs.
// ---------------------------------------------------------------------------
interface nexys_starship_tm_ctrl_if;

  logic       play_flag;
  logic       tick;
  logic       fire_top;
  logic       top_monster_ctrl;
  logic       top_timeout;
  logic       game_over_req;
  logic [7:0] hits;
  logic       q_Idle;
  logic       q_Wait;
  logic       q_Active;
  logic       q_Dead;

  modport slave (
    input  play_flag, tick, fire_top,
    output top_monster_ctrl, top_timeout, game_over_req, hits,
           q_Idle, q_Wait, q_Active, q_Dead
  );

  modport master (
    output play_flag, tick, fire_top,
    input  top_monster_ctrl, top_timeout, game_over_req, hits,
           q_Idle, q_Wait, q_Active, q_Dead
  );

endinterface

// File: rtl/nexys_starship_lfsr16.sv
// ---------------------------------------------------------------------------
// nexys_starship_lfsr16
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), one step per Clk.
// Ports:
//   Clk   : system clock, rising edge
//   Reset : asynchronous, active-low
//   seed  : value loaded while in reset; must be non-zero (caller guarantees)
//   q     : current register contents
// ---------------------------------------------------------------------------
module nexys_starship_lfsr16
  import nexys_starship_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Shift toward the MSB; the XOR of the tapped bits enters at bit 0.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAP_MASK)};
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      lfsr_q <= seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/nexys_starship_tm_ctrl.sv
// ---------------------------------------------------------------------------
// nexys_starship_tm_ctrl
// Top-monster timing controller: waits a pseudo-random gap, spawns a monster,
// and either counts a kill (fire_top) or declares the hull broken once the
// attack window runs out.
// Parameters:
//   LFSR_SEED    : LFSR reset value (0 is replaced by 16'h0001)
//   MIN_GAP      : minimum ticks between a kill/start and the next spawn
//   ATTACK_TICKS : ticks a spawned monster survives before breaking the hull
// Ports:
//   Clk   : system clock, rising edge
//   Reset : asynchronous, active-low
//   bus   : nexys_starship_tm_ctrl_if.slave (play_flag, tick, fire_top in;
//           top_monster_ctrl, top_timeout, game_over_req, hits, q_* out)
// Optional feature macro: NEXYS_STARSHIP_TM_DIFFICULTY_EN
//   Defined   : attack window shrinks by hits[7:3], never below ATK_FLOOR.
//   Undefined : attack window is always ATTACK_TICKS.
// ---------------------------------------------------------------------------
module nexys_starship_tm_ctrl
  import nexys_starship_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter logic [7:0]  MIN_GAP      = 8'd20,
  parameter logic [7:0]  ATTACK_TICKS = 8'd200
)
(
  input logic                       Clk,
  input logic                       Reset,
  nexys_starship_tm_ctrl_if.slave   bus
);

  // An all-zero seed would lock the LFSR, so it is swapped for 1.
  localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  state_e      state_q, state_d;
  logic        ctrl_q, ctrl_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  hits_q, hits_d;
  logic [7:0]  gap_q, gap_d;
  logic [7:0]  atk_q, atk_d;
  logic [15:0] lfsr_q;
  logic [7:0]  gap_load;
  logic [7:0]  atk_load;

  nexys_starship_lfsr16 u_lfsr (
    .Clk   (Clk),
    .Reset (Reset),
    .seed  (SEED_EFF),
    .q     (lfsr_q)
  );

  assign gap_load = sat_add8(MIN_GAP, {2'b00, lfsr_q[5:0]});

`ifdef NEXYS_STARSHIP_TM_DIFFICULTY_EN
  // max(ATK_FLOOR, ATTACK_TICKS - hits[7:3]) without unsigned underflow:
  // whenever ATTACK_TICKS < hits[7:3] + ATK_FLOOR the floor wins.
  logic [8:0] atk_floor_sum;
  assign atk_floor_sum = {4'b0000, hits_q[7:3]} + {1'b0, ATK_FLOOR};
  assign atk_load = ({1'b0, ATTACK_TICKS} < atk_floor_sum)
                    ? ATK_FLOOR
                    : (ATTACK_TICKS - {3'b000, hits_q[7:3]});
`else
  assign atk_load = ATTACK_TICKS;
`endif

  // Next-state logic. play_flag=0 aborts WAIT/ACTIVE/DEAD before anything
  // else; in ACTIVE a shot beats an expiring tick in the same cycle.
  // top_timeout is a one-cycle pulse, so it defaults low every cycle.
  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    timeout_d = 1'b0;
    hits_d    = hits_q;
    gap_d     = gap_q;
    atk_d     = atk_q;

    unique case (state_q)
      ST_IDLE: begin
        ctrl_d = 1'b0;
        if (bus.play_flag) begin
          state_d = ST_WAIT;
          gap_d   = gap_load;
          hits_d  = 8'd0;
        end
      end

      ST_WAIT: begin
        ctrl_d = 1'b0;
        if (!bus.play_flag) begin
          state_d = ST_IDLE;
        end else if (bus.tick) begin
          if (gap_q == 8'd0) begin
            state_d = ST_ACTIVE;
            ctrl_d  = 1'b1;
            atk_d   = atk_load;
          end else begin
            gap_d = gap_q - 8'd1;
          end
        end
      end

      ST_ACTIVE: begin
        ctrl_d = 1'b1;
        if (!bus.play_flag) begin
          state_d = ST_IDLE;
          ctrl_d  = 1'b0;
        end else if (bus.fire_top) begin
          state_d = ST_WAIT;
          ctrl_d  = 1'b0;
          hits_d  = sat_add8(hits_q, 8'd1);
          gap_d   = gap_load;
        end else if (bus.tick) begin
          // <=1 also catches a zero-length window instead of wrapping.
          if (atk_q <= 8'd1) begin
            state_d   = ST_DEAD;
            timeout_d = 1'b1;
          end else begin
            atk_d = atk_q - 8'd1;
          end
        end
      end

      ST_DEAD: begin
        ctrl_d = 1'b1;
        if (!bus.play_flag) begin
          state_d = ST_IDLE;
          ctrl_d  = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        ctrl_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset abandons any spawn or attack.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      ctrl_q    <= 1'b0;
      timeout_q <= 1'b0;
      hits_q    <= 8'd0;
      gap_q     <= 8'd0;
      atk_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      timeout_q <= timeout_d;
      hits_q    <= hits_d;
      gap_q     <= gap_d;
      atk_q     <= atk_d;
    end
  end

  // The gap only needs the low six LFSR bits, but the whole register must
  // never collapse to zero.
  lfsr_nonzero_a : assert property (@(posedge Clk) disable iff (!Reset) lfsr_q != 16'h0000);

  assign bus.top_monster_ctrl = ctrl_q;
  assign bus.top_timeout      = timeout_q;
  assign bus.game_over_req    = state_q[DEAD_BIT];
  assign bus.hits             = hits_q;
  assign bus.q_Idle           = state_q[IDLE_BIT];
  assign bus.q_Wait           = state_q[WAIT_BIT];
  assign bus.q_Active         = state_q[ACTIVE_BIT];
  assign bus.q_Dead           = state_q[DEAD_BIT];

endmodule

// File: tb/tb_nexys_starship_tm_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nexys_starship_tm_ctrl
// Drives two controllers (ATTACK_TICKS=4 and ATTACK_TICKS=20, MIN_GAP=2,
// default seed) with identical game inputs. A behavioural model predicts
// every output word; predictions are queued when inputs are applied and
// popped once the clock edge has happened.
// ---------------------------------------------------------------------------
module tb_nexys_starship_tm_ctrl;

  localparam int MIN_GAP_TB = 2;
  localparam int ATK_A      = 4;
  localparam int ATK_B      = 20;

`ifdef NEXYS_STARSHIP_TM_DIFFICULTY_EN
  localparam bit DIFF_EN = 1'b1;
`else
  localparam bit DIFF_EN = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset;

  always #5 Clk = ~Clk;

  nexys_starship_tm_ctrl_if bus_a ();
  nexys_starship_tm_ctrl_if bus_b ();

  nexys_starship_tm_ctrl #(
    .LFSR_SEED    (16'hACE1),
    .MIN_GAP      (8'd2),
    .ATTACK_TICKS (8'd4)
  ) dut_a (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus_a)
  );

  nexys_starship_tm_ctrl #(
    .LFSR_SEED    (16'hACE1),
    .MIN_GAP      (8'd2),
    .ATTACK_TICKS (8'd20)
  ) dut_b (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus_b)
  );

  // Model state: st 0=IDLE 1=WAIT 2=ACTIVE 3=DEAD
  typedef struct {
    int          st;
    int          gap;
    int          atk;
    int          hits;
    bit          ctrl;
    bit          tmo;
    logic [15:0] lfsr;
  } mdl_t;

  mdl_t        mdl [2];
  int          atk_param [2] = '{ATK_A, ATK_B};
  logic [14:0] exp_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.st   = 0;
    m.gap  = 0;
    m.atk  = 0;
    m.hits = 0;
    m.ctrl = 1'b0;
    m.tmo  = 1'b0;
    m.lfsr = 16'hACE1;
    return m;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input bit p, input bit t, input bit f,
                                    input int atk_ticks);
    mdl_t n;
    int   gl;
    int   al;
    n     = m;
    n.tmo = 1'b0;
    n.lfsr = {m.lfsr[14:0], m.lfsr[15] ^ m.lfsr[13] ^ m.lfsr[12] ^ m.lfsr[10]};
    gl = MIN_GAP_TB + int'(m.lfsr[5:0]);
    if (gl > 255) gl = 255;
    al = atk_ticks;
    if (DIFF_EN) begin
      al = atk_ticks - (m.hits / 8);
      if (al < 16) al = 16;
    end
    case (m.st)
      0: if (p) begin
        n.st = 1; n.gap = gl; n.hits = 0;
      end
      1: if (!p) begin
        n.st = 0; n.ctrl = 1'b0;
      end else if (t) begin
        if (m.gap == 0) begin
          n.st = 2; n.ctrl = 1'b1; n.atk = al;
        end else begin
          n.gap = m.gap - 1;
        end
      end
      2: if (!p) begin
        n.st = 0; n.ctrl = 1'b0;
      end else if (f) begin
        n.st = 1; n.ctrl = 1'b0; n.gap = gl;
        n.hits = (m.hits == 255) ? 255 : m.hits + 1;
      end else if (t) begin
        if (m.atk == 1) begin
          n.st = 3; n.tmo = 1'b1;
        end else begin
          n.atk = m.atk - 1;
        end
      end
      default: if (!p) begin
        n.st = 0; n.ctrl = 1'b0;
      end
    endcase
    return n;
  endfunction

  function automatic logic [14:0] mdl_vec(input mdl_t m);
    return {m.ctrl, m.tmo, (m.st == 3), 8'(m.hits),
            (m.st == 0), (m.st == 1), (m.st == 2), (m.st == 3)};
  endfunction

  function automatic logic [14:0] dut_vec(input int i);
    if (i == 0)
      return {bus_a.top_monster_ctrl, bus_a.top_timeout, bus_a.game_over_req, bus_a.hits,
              bus_a.q_Idle, bus_a.q_Wait, bus_a.q_Active, bus_a.q_Dead};
    else
      return {bus_b.top_monster_ctrl, bus_b.top_timeout, bus_b.game_over_req, bus_b.hits,
              bus_b.q_Idle, bus_b.q_Wait, bus_b.q_Active, bus_b.q_Dead};
  endfunction

  // Entered 1 time unit after a rising edge (or before the first one):
  // apply inputs, predict, take one edge, then compare.
  task automatic applyStimulus(input bit p, input bit t, input bit f);
    bus_a.play_flag = p; bus_a.tick = t; bus_a.fire_top = f;
    bus_b.play_flag = p; bus_b.tick = t; bus_b.fire_top = f;
    for (int i = 0; i < 2; i++) begin
      if (Reset) mdl[i] = mdl_step(mdl[i], p, t, f, atk_param[i]);
      else       mdl[i] = mdl_reset();
      exp_q.push_back(mdl_vec(mdl[i]));
    end
    @(posedge Clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput((i == 0) ? "cycle_a" : "cycle_b", {17'd0, dut_vec(i)}, {17'd0, exp_q.pop_front()});
    end
  endtask

  // Ticks every cycle until dut_a shows a monster; returns the tick count.
  task automatic tickUntilSpawn(input int bound, output int n);
    n = 0;
    do begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      n++;
    end while (!bus_a.top_monster_ctrl && n < bound);
  endtask

  localparam logic [14:0] RESET_VEC = {3'b000, 8'd0, 4'b1000};

  initial begin : watchdog
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int n;
    int guard;
    int tmo_a;
    int tmo_b;
    int pulses;
    bit spawn_ok;
    int exp_atk_a;
    int exp_atk_b;

    exp_atk_a = DIFF_EN ? 16 : ATK_A;
    Reset = 1'b1;
    bus_a.play_flag = 1'b0; bus_a.tick = 1'b0; bus_a.fire_top = 1'b0;
    bus_b.play_flag = 1'b0; bus_b.tick = 1'b0; bus_b.fire_top = 1'b0;
    mdl[0] = mdl_reset();
    mdl[1] = mdl_reset();
    #1 Reset = 1'b0;
    #1;
    checkOutput("reset_a", {17'd0, dut_vec(0)}, {17'd0, RESET_VEC});
    checkOutput("reset_b", {17'd0, dut_vec(1)}, {17'd0, RESET_VEC});
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b1);
    Reset = 1'b1;

    // Spawn after the minimum gap: start when lfsr[5:0]==0 so gap = 2.
    guard = 0;
    while (mdl[0].lfsr[5:0] != 6'd0 && guard < 2000) begin
      applyStimulus(1'b0, 1'b1, 1'b1);
      guard++;
    end
    checkOutput("lfsr_align", {31'd0, guard < 2000}, 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("wait_entry", {31'd0, bus_a.q_Wait}, 32'd1);
    tickUntilSpawn(20, n);
    checkOutput("spawn_tick", n, 32'd3);

    // Kill the active monster.
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("kill_ctrl", {31'd0, bus_a.top_monster_ctrl}, 32'd0);
    checkOutput("kill_hits", {24'd0, bus_a.hits}, 32'd1);
    checkOutput("kill_wait", {31'd0, bus_a.q_Wait}, 32'd1);

    // Let the next monster break the hull.
    tickUntilSpawn(100, n);
    checkOutput("respawn", {31'd0, bus_a.top_monster_ctrl}, 32'd1);
    tmo_a = 0; pulses = 0;
    for (int k = 1; k <= exp_atk_a + 4; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      if (bus_a.top_timeout) begin
        pulses++;
        if (tmo_a == 0) tmo_a = k;
      end
    end
    checkOutput("timeout_tick", tmo_a, exp_atk_a);
    checkOutput("timeout_pulses", pulses, 32'd1);
    checkOutput("dead_gameover", {31'd0, bus_a.game_over_req}, 32'd1);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("dead_hold", {31'd0, bus_a.q_Dead}, 32'd1);
    checkOutput("dead_hits_kept", {24'd0, bus_a.hits}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("dead_exit", {31'd0, bus_a.q_Idle}, 32'd1);

    // Shot on the expiring tick wins over the timeout.
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("hits_cleared", {24'd0, bus_a.hits}, 32'd0);
    tickUntilSpawn(100, n);
    repeat (exp_atk_a - 1) applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("race_hits", {24'd0, bus_a.hits}, 32'd1);
    checkOutput("race_timeout", {31'd0, bus_a.top_timeout}, 32'd0);
    checkOutput("race_wait", {31'd0, bus_a.q_Wait}, 32'd1);

    // Saturate the kill counter.
    spawn_ok = 1'b1;
    for (int kk = 0; kk < 300 && spawn_ok; kk++) begin
      tickUntilSpawn(100, n);
      if (!bus_a.top_monster_ctrl) spawn_ok = 1'b0;
      else applyStimulus(1'b1, 1'b0, 1'b1);
    end
    checkOutput("kill_loop_spawns", {31'd0, spawn_ok}, 32'd1);
    checkOutput("hits_sat", {24'd0, bus_a.hits}, 32'd255);

    // Attack window after saturation (hits[7:3] = 31).
    exp_atk_b = DIFF_EN ? 16 : ATK_B;
    tickUntilSpawn(100, n);
    tmo_a = 0; tmo_b = 0;
    for (int k = 1; k <= 40; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      if (bus_a.top_timeout && tmo_a == 0) tmo_a = k;
      if (bus_b.top_timeout && tmo_b == 0) tmo_b = k;
    end
    checkOutput("atk_len_a", tmo_a, exp_atk_a);
    checkOutput("atk_len_b", tmo_b, exp_atk_b);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Reset in the middle of an attack.
    applyStimulus(1'b1, 1'b0, 1'b0);
    tickUntilSpawn(100, n);
    applyStimulus(1'b1, 1'b1, 1'b0);
    #2 Reset = 1'b0;
    #1;
    checkOutput("async_reset_a", {17'd0, dut_vec(0)}, {17'd0, RESET_VEC});
    checkOutput("async_reset_b", {17'd0, dut_vec(1)}, {17'd0, RESET_VEC});
    mdl[0] = mdl_reset();
    mdl[1] = mdl_reset();
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0);
    Reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("restart_wait", {31'd0, bus_a.q_Wait}, 32'd1);
    tickUntilSpawn(100, n);
    checkOutput("restart_spawn", {31'd0, bus_a.top_monster_ctrl}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
